// File: rtl/audio_clkgen_pkg.sv
// Shared audio frame constants, TDM index types and the startup state encoding.
// Pure definitions: no logic, no latency, no flow control.
package audio_clkgen_pkg;

  localparam int FRAME_CYCLES   = 256;
  localparam int PHASE_W        = 8;
  localparam int BITS_PER_FRAME = 128;

  typedef logic [1:0] slot_t;
  typedef logic [4:0] bit_idx_t;

  typedef enum logic [1:0] {
    PDN_HOLD,
    SETTLE,
    RUN
  } startup_state_t;

  // The bit clock runs at 128fs, so the TDM geometry must fill exactly 128 bit periods.
  function automatic bit tdm_geometry_ok(input int n_slots, input int bits_per_slot);
    return (n_slots * bits_per_slot) == BITS_PER_FRAME;
  endfunction

endpackage

// File: rtl/audio_startup_seq.sv
// Codec power-down release then frame-counted settle; outputs registered one cycle after the decision.
// No backpressure: free-running on clk_256fs, monotonic until reset.
module audio_startup_seq
  import audio_clkgen_pkg::*;
#(
  parameter int PDN_CYCLES    = 1024,
  parameter int SETTLE_FRAMES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_frame_wrap,
  output logic o_codec_pdn_n,
  output logic o_ready
);

  localparam int PDN_W = $clog2(PDN_CYCLES + 1);
  localparam int FRM_W = $clog2(SETTLE_FRAMES + 1);

  startup_state_t   r_state;
  startup_state_t   w_state_nxt;
  logic [PDN_W-1:0] r_pdn_cnt;
  logic [PDN_W-1:0] w_pdn_cnt_nxt;
  logic [FRM_W-1:0] r_frm_cnt;
  logic [FRM_W-1:0] w_frm_cnt_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_pdn_cnt_nxt = r_pdn_cnt;
    w_frm_cnt_nxt = r_frm_cnt;
    case (r_state)
      PDN_HOLD: begin
        if (r_pdn_cnt == '0) w_state_nxt = SETTLE;
        else                 w_pdn_cnt_nxt = r_pdn_cnt - PDN_W'(1);
      end
      SETTLE: begin
        // Only wraps seen after PDN release count toward the settle interval.
        if (i_frame_wrap) begin
          w_frm_cnt_nxt = r_frm_cnt + FRM_W'(1);
          if (r_frm_cnt == FRM_W'(SETTLE_FRAMES - 1)) w_state_nxt = RUN;
        end
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = PDN_HOLD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= PDN_HOLD;
      r_pdn_cnt     <= PDN_W'(PDN_CYCLES - 1);
      r_frm_cnt     <= '0;
      o_codec_pdn_n <= 1'b0;
      o_ready       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pdn_cnt     <= w_pdn_cnt_nxt;
      r_frm_cnt     <= w_frm_cnt_nxt;
      o_codec_pdn_n <= (w_state_nxt != PDN_HOLD);
      o_ready       <= (w_state_nxt == RUN);
    end
  end

endmodule

// File: rtl/audio_clkgen.sv
// 256fs phase counter decoded into registered BICK/LRCK/TDM indices/strobes plus codec startup sequencing.
// Outputs are flops tracking the phase of the same cycle; no backpressure, runs continuously outside reset.
module audio_clkgen
  import audio_clkgen_pkg::*;
#(
  parameter int BITS_PER_SLOT = 32,
  parameter int N_SLOTS       = 4,
  parameter int PDN_CYCLES    = 1024,
  parameter int SETTLE_FRAMES = 16
) (
  input  logic                             clk_256fs,
  input  logic                             rst,
  output logic                             bick,
  output logic                             lrck,
  output logic [$clog2(N_SLOTS)-1:0]       slot,
  output logic [$clog2(BITS_PER_SLOT)-1:0] bit_idx,
  output logic                             shift_strobe,
  output logic                             sample_strobe,
  output logic                             codec_pdn_n,
  output logic                             ready
);

  localparam int SLOT_W = $clog2(N_SLOTS);
  localparam int BIT_W  = $clog2(BITS_PER_SLOT);

  if (!tdm_geometry_ok(N_SLOTS, BITS_PER_SLOT)) begin : g_bad_geometry
    $error("audio_clkgen: N_SLOTS*BITS_PER_SLOT must equal 128");
  end
  if (PDN_CYCLES < 1 || SETTLE_FRAMES < 1) begin : g_bad_startup
    $error("audio_clkgen: PDN_CYCLES and SETTLE_FRAMES must be >= 1");
  end

  logic [PHASE_W-1:0] r_p;
  logic               r_started;
  logic [PHASE_W-1:0] w_p_nxt;
  logic               w_frame_wrap;

  // The first edge out of reset loads phase 0 so the codec sees a clean frame start.
  assign w_p_nxt      = r_started ? (r_p + PHASE_W'(1)) : '0;
  assign w_frame_wrap = r_started && (r_p == PHASE_W'(FRAME_CYCLES - 1));

  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      r_p           <= '0;
      r_started     <= 1'b0;
      bick          <= 1'b0;
      lrck          <= 1'b0;
      slot          <= '0;
      bit_idx       <= '0;
      shift_strobe  <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      r_p           <= w_p_nxt;
      r_started     <= 1'b1;
      bick          <= w_p_nxt[0];
      lrck          <= ~w_p_nxt[PHASE_W-1];
      slot          <= w_p_nxt[PHASE_W-1 -: SLOT_W];
      bit_idx       <= w_p_nxt[BIT_W:1];
      shift_strobe  <= w_p_nxt[0];
      // Uses ready from before this edge, so the wrap that completes settling stays silent.
      sample_strobe <= ready && (w_p_nxt == '0);
    end
  end

  audio_startup_seq #(
    .PDN_CYCLES    (PDN_CYCLES),
    .SETTLE_FRAMES (SETTLE_FRAMES)
  ) u_startup (
    .i_clk         (clk_256fs),
    .i_rst         (rst),
    .i_frame_wrap  (w_frame_wrap),
    .o_codec_pdn_n (codec_pdn_n),
    .o_ready       (ready)
  );

endmodule

// File: tb/tb_audio_clkgen.sv
// Randomised reset scenarios against a cycles-since-release reference model, scoreboarded per cycle.
module tb_audio_clkgen;
  import audio_clkgen_pkg::*;

  localparam int P = 8;
  localparam int S = 2;

  logic     clk_256fs = 1'b0;
  logic     rst       = 1'b1;
  logic     bick, lrck, shift_strobe, sample_strobe, codec_pdn_n, ready;
  slot_t    slot;
  bit_idx_t bit_idx;

  typedef struct packed {
    logic     bick;
    logic     lrck;
    slot_t    slot;
    bit_idx_t bit_idx;
    logic     shift_strobe;
    logic     sample_strobe;
    logic     codec_pdn_n;
    logic     ready;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   k      = 0;

  audio_clkgen #(
    .BITS_PER_SLOT (32),
    .N_SLOTS       (4),
    .PDN_CYCLES    (P),
    .SETTLE_FRAMES (S)
  ) dut (
    .clk_256fs     (clk_256fs),
    .rst           (rst),
    .bick          (bick),
    .lrck          (lrck),
    .slot          (slot),
    .bit_idx       (bit_idx),
    .shift_strobe  (shift_strobe),
    .sample_strobe (sample_strobe),
    .codec_pdn_n   (codec_pdn_n),
    .ready         (ready)
  );

  always #5 clk_256fs = ~clk_256fs;

  // kk = number of clock edges sampled with reset low since the last reset edge.
  function automatic obs_t model(input int kk);
    obs_t o;
    int   ph, m_first, k_ready;
    o = '0;
    if (kk == 0) return o;
    ph      = (kk - 1) % FRAME_CYCLES;
    // Frame wraps land on edges kk = 1 + 256*m; only those after PDN release count.
    m_first = (P - 1) / FRAME_CYCLES + 1;
    k_ready = 1 + FRAME_CYCLES * (m_first + S - 1);
    o.bick          = (ph % 2) == 1;
    o.lrck          = ph < 128;
    o.slot          = slot_t'(ph / 64);
    o.bit_idx       = bit_idx_t'((ph % 64) / 2);
    o.shift_strobe  = (ph % 2) == 1;
    o.codec_pdn_n   = kk >= P;
    o.ready         = kk >= k_ready;
    o.sample_strobe = (kk > k_ready) && (ph == 0);
    return o;
  endfunction

  task automatic step();
    @(posedge clk_256fs);
    #1;
    k = rst ? 0 : k + 1;
    exp_q.push_back(model(k));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Monitor: pops one expectation per observed cycle and checks strobe spacing.
  initial begin
    obs_t e, a;
    int   cyc = 0;
    int   last_strobe = -1;
    forever begin
      @(negedge clk_256fs);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bick, lrck, slot, bit_idx, shift_strobe, sample_strobe, codec_pdn_n, ready};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d actual=%h required=%h", cyc, a, e);
        end
        if (!e.ready) last_strobe = -1;
        if (sample_strobe === 1'b1) begin
          if (last_strobe >= 0) begin
            checks++;
            if (cyc - last_strobe != FRAME_CYCLES) begin
              errors++;
              $display("FAIL strobe_period cyc=%0d actual=%0d required=%0d", cyc, cyc - last_strobe, FRAME_CYCLES);
            end
          end
          last_strobe = cyc;
        end
        cyc++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    run(3);

    // Cold start through settle and four RUN frames.
    rst = 1'b0;
    run(513 + 4 * FRAME_CYCLES + 5);

    // One-cycle reset while in RUN at a random phase, then a full restart.
    run($urandom_range(0, 255));
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Reset mid-SETTLE on the cycle where p == 137.
    while (k < 257 || (k % FRAME_CYCLES) != 138) step();
    rst = 1'b1;
    run($urandom_range(1, 3));
    rst = 1'b0;
    run(513 + 2 * FRAME_CYCLES + 3);

    // Random reset pulses at random points in the startup sequence.
    for (int i = 0; i < 6; i++) begin
      run($urandom_range(1, 1100));
      rst = 1'b1;
      run($urandom_range(1, 4));
      rst = 1'b0;
    end
    run(513 + 3 * FRAME_CYCLES);

    repeat (3) @(negedge clk_256fs);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
